// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two bypassed read ports, two write ports
// and a per-register busy scoreboard; x0 reads zero and is never busy.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rs1_addr/rs2_addr   read addresses
//   rs1_data/rs2_data   read data (comb, write-through bypass, port 1 first)
//   rs1_busy/rs2_busy   outstanding producer, not retiring this cycle
//   we0/waddr0/wdata0   ALU writeback port
//   we1/waddr1/wdata1   load writeback port (wins on address collision)
//   issue_en/issue_rd   issuing instruction marks its destination busy
//   waw_hazard          issue targets a register still busy after writebacks
//   busy_vec            registered busy bits
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [XLEN-1:0]  wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [XLEN-1:0]  wdata1,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  output logic             waw_hazard,
  output logic [NREGS-1:0] busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] set_vec;

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (we0) clr_vec[waddr0] = 1'b1;
    if (we1) clr_vec[waddr1] = 1'b1;
    if (issue_en) set_vec[issue_rd] = 1'b1;
    clr_vec[0] = 1'b0;
    set_vec[0] = 1'b0;
    // set after clear: a new producer may issue as the old one retires
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_comb begin
    regs_d = regs_q;
    if (we0 && waddr0 != '0) regs_d[waddr0] = wdata0;
    if (we1 && waddr1 != '0) regs_d[waddr1] = wdata1;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (we0 && waddr0 == rs1_addr) rs1_data = wdata0;
    if (we1 && waddr1 == rs1_addr) rs1_data = wdata1;
    if (rs1_addr == '0) rs1_data = '0;
  end

  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (we0 && waddr0 == rs2_addr) rs2_data = wdata0;
    if (we1 && waddr1 == rs2_addr) rs2_data = wdata1;
    if (rs2_addr == '0) rs2_data = '0;
  end

  // busy_q[0] and clr_vec[0] are always 0, so x0 never reports busy
  assign rs1_busy   = busy_q[rs1_addr] & ~clr_vec[rs1_addr];
  assign rs2_busy   = busy_q[rs2_addr] & ~clr_vec[rs2_addr];
  assign waw_hazard = issue_en & busy_q[issue_rd]
                    & ~clr_vec[issue_rd];
  assign busy_vec   = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random vectors for regfile_sb,
// checked every cycle against an array-based reference model.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [AW-1:0]    rs1_addr, rs2_addr;
  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic             rs1_busy, rs2_busy;
  logic             we0, we1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [XLEN-1:0]  wdata0, wdata1;
  logic             issue_en;
  logic [AW-1:0]    issue_rd;
  logic             waw_hazard;
  logic [NREGS-1:0] busy_vec;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .waw_hazard(waw_hazard), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_wb(logic [AW-1:0] a);
    return (we0 && waddr0 == a) || (we1 && waddr1 == a);
  endfunction

  function automatic logic [XLEN-1:0] m_read(logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return m_regs[a];
  endfunction

  function automatic bit m_rbusy(logic [AW-1:0] a);
    return a != 0 && m_busy[a] && !m_wb(a);
  endfunction

  function automatic logic [NREGS-1:0] m_bvec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    rs1_addr = '0; rs2_addr = '0;
    we0 = 0; waddr0 = '0; wdata0 = '0;
    we1 = 0; waddr1 = '0; wdata1 = '0;
    issue_en = 0; issue_rd = '0;
  endtask

  // compare now, then advance one clock and update the model
  task automatic cycle();
    bit wb;
    #1;
    chk("rs1_data", rs1_data, m_read(rs1_addr));
    chk("rs2_data", rs2_data, m_read(rs2_addr));
    chk("rs1_busy", rs1_busy, m_rbusy(rs1_addr));
    chk("rs2_busy", rs2_busy, m_rbusy(rs2_addr));
    chk("waw_hazard", waw_hazard,
        issue_en && issue_rd != 0 && m_rbusy(issue_rd));
    chk("busy_vec", busy_vec, m_bvec());
    @(posedge clk);
    for (int r = 1; r < NREGS; r++) begin
      wb = m_wb(r[AW-1:0]);
      if (issue_en && issue_rd == r) m_busy[r] = 1'b1;
      else if (wb) m_busy[r] = 1'b0;
    end
    if (we0 && waddr0 != 0) m_regs[waddr0] = wdata0;
    if (we1 && waddr1 != 0) m_regs[waddr1] = wdata1;
    @(negedge clk);
  endtask

  initial begin
    idle();
    m_reset();
    rst_n = 1'b0;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    cycle();

    // load some state, then async reset mid-cycle
    we0 = 1; waddr0 = 5; wdata0 = 32'h55;
    issue_en = 1; issue_rd = 6;
    cycle();
    idle();
    we1 = 1; waddr1 = 6; wdata1 = 32'h66;
    issue_en = 1; issue_rd = 4;
    #2 rst_n = 1'b0;
    #1 chk("rst_busy_vec", busy_vec, 0);
    m_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    rs1_addr = 5;
    #1 chk("rst_x5", rs1_data, 0);
    cycle();

    // bypass and port priority
    idle();
    we0 = 1; waddr0 = 7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 7; wdata1 = 32'h22;
    rs1_addr = 7;
    #1 chk("bypass_p1", rs1_data, 32'h22);
    cycle();
    idle();
    rs1_addr = 7;
    #1 chk("x7_stored", rs1_data, 32'h22);
    cycle();

    // x0 write and issue are ignored
    idle();
    we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
    issue_en = 1; issue_rd = 0;
    #1 chk("x0_read", rs1_data, 0);
    chk("x0_waw", waw_hazard, 0);
    cycle();
    idle();
    #1 chk("x0_busy", busy_vec[0], 0);
    cycle();

    // scoreboard lifetime of x3
    idle();
    issue_en = 1; issue_rd = 3;
    cycle();
    idle();
    rs2_addr = 3;
    for (int c = 2; c <= 4; c++) begin
      #1 chk("x3_busy", rs2_busy, 1);
      cycle();
    end
    we1 = 1; waddr1 = 3; wdata1 = 32'hAB;
    #1 chk("x3_wb_busy", rs2_busy, 0);
    chk("x3_wb_data", rs2_data, 32'hAB);
    cycle();
    idle();
    rs2_addr = 3;
    #1 chk("x3_vec", busy_vec[3], 0);
    chk("x3_data", rs2_data, 32'hAB);
    cycle();

    // set overrides clear, then true WAW
    idle();
    issue_en = 1; issue_rd = 9;
    cycle();
    we0 = 1; waddr0 = 9; wdata0 = 32'h99;
    #1 chk("x9_waw_clr", waw_hazard, 0);
    cycle();
    idle();
    #1 chk("x9_still", busy_vec[9], 1);
    issue_en = 1; issue_rd = 9;
    #1 chk("x9_waw", waw_hazard, 1);
    cycle();

    // writeback to a non-busy register
    idle();
    we1 = 1; waddr1 = 12; wdata1 = 32'hC0DE;
    cycle();
    idle();
    rs1_addr = 12;
    #1 chk("x12_data", rs1_data, 32'hC0DE);
    chk("x12_busy", busy_vec[12], 0);
    cycle();

    // random traffic, biased to a few registers for collisions
    for (int k = 0; k < 3000; k++) begin
      rs1_addr = AW'($urandom_range(0, 7));
      rs2_addr = AW'($urandom_range(0, 31));
      we0 = 1'($urandom);
      waddr0 = AW'($urandom_range(0, 7));
      wdata0 = $urandom;
      we1 = 1'($urandom);
      waddr1 = AW'($urandom_range(0, 7));
      wdata1 = $urandom;
      issue_en = 1'($urandom);
      issue_rd = AW'($urandom_range(0, 7));
      cycle();
    end

    idle();
    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
